// File: rtl/single_stage_pipeline_pkg.sv
// Shared constants for the single-stage skid-buffer register slice.
package single_stage_pipeline_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/single_stage_pipeline.sv
// Full-throughput register slice: a main output register backed by one skid
// register, so in_ready and out_valid/out_data are all driven straight from flops.
module single_stage_pipeline
  import single_stage_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  main_valid_q, main_valid_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  in_ready_q, in_ready_d;

  logic in_xfer;
  logic out_xfer;
  logic main_free;

  always_comb begin
    in_xfer   = in_valid && in_ready_q;
    out_xfer  = main_valid_q && out_ready;
    main_free = !main_valid_q || out_xfer;

    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (main_free) begin
      // Skid holds the older beat, so it always refills main first; in_ready
      // is low whenever skid is full, so no new beat competes with it.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

endmodule

// File: tb/tb_single_stage_pipeline.sv
// Scoreboard bench for the skid-buffer register slice: the driver queues every
// accepted beat, and a negedge monitor pops and compares each output transfer.
module tb_single_stage_pipeline;

  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  single_stage_pipeline #(.DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on every output transfer, and checks hold-stability while stalled.
  initial begin
    logic          stall_prev;
    logic [DW-1:0] stall_data;
    stall_prev = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid", DW'(out_valid), DW'(1));
          check("stall_data", out_data, stall_data);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %h expected no beat at %0t", out_data, $time);
          end else begin
            check("out_beat", out_data, exp_q.pop_front());
          end
        end
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d beats outstanding expected 0", name, exp_q.size());
    end
    check({name, "_idle"}, DW'(out_valid), DW'(0));
  endtask

  initial begin
    logic [DW-1:0] beats[10];
    int sent;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset for three cycles, then check the idle state.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_out_data", out_data, DW'(0));
    check("rst_in_ready", DW'(in_ready), DW'(1));
    step();

    // Back-to-back beats with downstream always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [DW-1:0] v;
      v = DW'(32'h1111_1111 * (i + 1));
      in_valid = 1'b1;
      in_data  = v;
      exp_q.push_back(v);
      @(negedge clk);
      check("b2b_in_ready", DW'(in_ready), DW'(1));
      step();
      check("b2b_latency", out_data, v);
      check("b2b_valid", DW'(out_valid), DW'(1));
    end
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    wait_empty("b2b_drain", 10);

    // Stall: A in main, B in skid, C pending with in_ready low.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    exp_q.push_back(32'hA);
    step();
    check("stall_in_ready_a", DW'(in_ready), DW'(1));
    in_data = 32'hB;
    exp_q.push_back(32'hB);
    step();
    check("skid_out_data", out_data, 32'hA);
    check("skid_in_ready", DW'(in_ready), DW'(0));
    in_data = 32'hC;
    exp_q.push_back(32'hC);
    repeat (2) begin
      step();
      check("hold_out_data", out_data, 32'hA);
      check("hold_in_ready", DW'(in_ready), DW'(0));
    end
    out_ready = 1'b1;
    step();
    check("unstall_out_b", out_data, 32'hB);
    check("unstall_in_ready", DW'(in_ready), DW'(1));
    step();
    in_valid = 1'b0;
    in_data  = 32'h0BAD_0BAD;
    check("unstall_out_c", out_data, 32'hC);
    check("unstall_valid_c", DW'(out_valid), DW'(1));
    wait_empty("stall_drain", 10);

    // Random backpressure and gaps; in_data is garbage whenever in_valid is low.
    foreach (beats[i]) beats[i] = $urandom;
    sent = 0;
    for (int cyc = 0; cyc < 200 && (sent < 10 || cyc < 20); cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 10 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = beats[sent];
      end else begin
        in_valid = 1'b0;
        in_data  = $urandom;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        sent++;
      end
      step();
    end
    checks++;
    if (sent != 10) begin
      errors++;
      $display("FAIL rand_sent: got %0d beats accepted expected 10", sent);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_empty("rand_drain", 20);

    // Reset with two beats buffered, racing a handshake on the same edge.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1234;
    step();
    in_data = 32'h5678;
    step();
    in_valid = 1'b0;
    check("full_out_valid", DW'(out_valid), DW'(1));
    check("full_out_data", out_data, 32'h1234);
    check("full_in_ready", DW'(in_ready), DW'(0));
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h9999;
    step();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    check("midrst_out_valid", DW'(out_valid), DW'(0));
    check("midrst_out_data", out_data, DW'(0));
    check("midrst_in_ready", DW'(in_ready), DW'(1));
    repeat (4) begin
      step();
      check("postrst_out_valid", DW'(out_valid), DW'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/single_stage_pipeline.md
SINGLE_STAGE_PIPELINE -- requirements
Module: single_stage_pipeline

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter DATA_WIDTH SHALL default to 32 and give the payload width in bits.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit wide: synchronous reset, active-high; rst_n=1 at a rising edge SHALL reset the block.
REQ-005 Port in_valid SHALL be an input, 1 bit wide: the upstream beat is valid.
REQ-006 Port in_ready SHALL be an output, 1 bit wide: the block can accept a beat this cycle.
REQ-007 Port in_data SHALL be an input, DATA_WIDTH bits wide: the upstream payload.
REQ-008 Port out_valid SHALL be an output, 1 bit wide: out_data holds a valid beat.
REQ-009 Port out_ready SHALL be an input, 1 bit wide: downstream accepts the beat this cycle.
REQ-010 Port out_data SHALL be an output, DATA_WIDTH bits wide: the downstream payload.

Function
REQ-011 The block SHALL be a full-throughput register slice (skid buffer) made of a main register (out_valid, out_data) and one skid register (skid_valid, skid_data).
REQ-012 An input transfer SHALL occur when in_valid && in_ready at a rising edge; an output transfer SHALL occur when out_valid && out_ready at a rising edge.
REQ-013 in_ready SHALL be driven only by a register, with in_ready = !skid_valid; it SHALL have no combinational path from out_ready or in_valid.
REQ-014 out_valid and out_data SHALL come straight from registers, with no combinational path from any input.
REQ-015 Latency SHALL be 1 cycle: a beat accepted into an empty main register appears on out_data at the next cycle.
REQ-016 Throughput SHALL be 1 beat per cycle while out_ready stays at 1.
REQ-017 When the main register is empty or draining this cycle and skid is empty, an accepted beat SHALL load the main register.
REQ-018 When the main register is full and not draining, an accepted beat SHALL load skid; in_ready SHALL be 0 from the next cycle.
REQ-019 When skid is full and the main register drains, skid SHALL move into the main register and skid SHALL clear, so in_ready=1 at the next cycle.
REQ-020 Beats SHALL leave in arrival order, with no loss, duplication or reordering.
REQ-021 While out_valid && !out_ready, out_data and out_valid SHALL hold stable.
REQ-022 in_data SHALL be ignored in any cycle with no input transfer.
REQ-023 With neither transfer in a cycle, all state SHALL hold.
REQ-024 Simultaneous input and output transfer with skid empty SHALL replace the main register contents with the new beat.
REQ-025 The block SHALL hold at most 2 beats; when both registers are full, in_ready SHALL be 0.

Reset
REQ-026 While rst_n=1 at a rising edge, the block SHALL set out_valid=0, out_data=0, skid_valid=0, skid_data=0 and in_ready=1.
REQ-027 Reset asserted mid-operation SHALL discard every buffered beat at that edge, with no output transfer afterwards for those beats.
REQ-028 Reset SHALL take priority over any simultaneous handshake.

Structure
REQ-029 The shared package single_stage_pipeline_pkg SHALL hold the DATA_WIDTH default constant; no typedefs are needed.
REQ-030 The block SHALL be a single module with no sub-module; the skid register SHALL be coded inline.

Verification
REQ-031 Reset for 3 cycles, all inputs 0 -> out_valid=0, out_data=0, in_ready=1 once reset releases.
REQ-032 With out_ready=1, send 5 beats back-to-back (0x11111111..0x55555555) -> each beat appears 1 cycle later, in order, and in_ready stays 1.
REQ-033 Hold out_ready=0 and send 0xA and 0xB -> out_data=0xA is held, 0xB goes to skid, in_ready=0 and 0xC stays pending; then set out_ready=1 -> outputs 0xA, 0xB, 0xC in that order.
REQ-034 Drive random out_ready for 20 cycles with 10 random beats -> a scoreboard confirms every beat arrives exactly once and in order, and out_data stays stable while stalled.
REQ-035 Assert reset while 2 beats are buffered -> out_valid=0 and in_ready=1 at the next cycle, and the buffered beats never appear.
